// File: rtl/rd_ddr_burst_ctrl_if.sv
// AXI4 read-address and read-data channel bundle for rd_ddr_burst_ctrl.
//   master modport : the burst controller. It drives AR and rready and
//                    samples arready and the R channel.
//   slave modport  : the memory side, with all directions reversed.
// Parameters: AW = address width, DW = data width.
interface rd_ddr_burst_ctrl_if #(
  parameter int AW = 32,
  parameter int DW = 512
);
  logic [AW-1:0] araddr;
  logic [7:0]    arlen;
  logic [2:0]    arsize;
  logic [1:0]    arburst;
  logic          arvalid;
  logic          arready;
  logic [DW-1:0] rdata;
  logic [1:0]    rresp;
  logic          rlast;
  logic          rvalid;
  logic          rready;

  modport master (
    output araddr, arlen, arsize, arburst, arvalid, rready,
    input  arready, rdata, rresp, rlast, rvalid
  );

  modport slave (
    input  araddr, arlen, arsize, arburst, arvalid, rready,
    output arready, rdata, rresp, rlast, rvalid
  );
endinterface

// File: rtl/rd_ddr_burst_ctrl.sv
// DDR read burst controller.
// The controller accepts read commands of the form (queue, byte count, flag).
// It splits each command into AXI4 INCR read bursts and forwards the read
// data downstream. A last marker is raised on the final beat of the whole
// command. When the command is complete, a one-cycle finish pulse is issued.
// Each queue owns a region of P_QUEUE_SPACE bytes. The read pointer of a
// queue wraps circularly inside that region.
// Ports:
//   i_clk, i_rst_n            clock, asynchronous active-low reset
//   i_rd_*                    command channel (valid/ready handshake)
//   o_rd_byte_ready           command ready, high only while idle
//   o_rd_queue_finish         one-cycle pulse: the command is done
//   o_req_err                 one-cycle pulse: queue index out of range
//   m_axi                     AXI4 AR + R channels (master modport)
//   o_rd_data/flag/valid/last downstream beat, with i_rd_ready as ready
//   o_rresp_err               sticky: a nonzero rresp was seen since reset
module rd_ddr_burst_ctrl #(
  parameter int          C_M_AXI_ADDR_WIDTH = 32,
  parameter int          C_M_AXI_DATA_WIDTH = 512,
  parameter int          P_DDR_LOCAL_QUEUE  = 4,
  parameter int          P_QUEUE_NUM        = 8,
  parameter logic [31:0] P_QUEUE_SPACE      = 32'h0040_0000,
  parameter int          P_MAX_BURST_LEN    = 64
) (
  input  logic                          i_clk,
  input  logic                          i_rst_n,
  input  logic                          i_rd_flag,
  input  logic [P_DDR_LOCAL_QUEUE-1:0]  i_rd_queue,
  input  logic [C_M_AXI_ADDR_WIDTH-1:0] i_rd_byte,
  input  logic                          i_rd_byte_valid,
  output logic                          o_rd_byte_ready,
  output logic                          o_rd_queue_finish,
  output logic                          o_req_err,
  rd_ddr_burst_ctrl_if.master           m_axi,
  output logic [C_M_AXI_DATA_WIDTH-1:0] o_rd_data,
  output logic                          o_rd_flag,
  output logic                          o_rd_valid,
  output logic                          o_rd_last,
  input  logic                          i_rd_ready,
  output logic                          o_rresp_err
);

  localparam int AW     = C_M_AXI_ADDR_WIDTH;
  localparam int DW     = C_M_AXI_DATA_WIDTH;
  localparam int QW     = P_DDR_LOCAL_QUEUE;
  localparam int BYTES  = DW / 8;
  localparam int BSHIFT = $clog2(BYTES);
  localparam int LEN_W  = 9;
  localparam int QIDX_W = (P_QUEUE_NUM > 1) ? $clog2(P_QUEUE_NUM) : 1;
  localparam logic [QW:0] QNUM = (QW + 1)'(P_QUEUE_NUM);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    CALC   = 3'd1,
    AR     = 3'd2,
    RDATA  = 3'd3,
    FINISH = 3'd4
  } state_t;

  // Unsigned minimum, used to clamp the burst length.
  function automatic logic [AW-1:0] min_u(input logic [AW-1:0] a, input logic [AW-1:0] b);
    return (a < b) ? a : b;
  endfunction

  state_t             state_r;
  state_t             state_nx_s;
  logic               ready_r;
  logic [QW-1:0]      queue_r;
  logic               queue_bad_r;
  logic               flag_r;
  logic [AW-1:0]      rem_r;
  logic [LEN_W-1:0]   len_r;
  logic [AW-1:0]      araddr_r;
  logic [7:0]         arlen_r;
  logic               rresp_err_r;
  logic [AW-1:0]      ptr_r [P_QUEUE_NUM];

  logic [QIDX_W-1:0]  qidx_s;
  logic [AW-1:0]      ptr_cur_s;
  logic [AW-1:0]      tail_s;
  logic [LEN_W-1:0]   len_s;
  logic [AW-1:0]      base_s;
  logic [AW-1:0]      ptr_nx_s;
  logic [AW:0]        byte_sum_s;
  logic [AW-1:0]      beats_s;
  logic               in_rdata_s;
  logic               r_hs_s;

  assign qidx_s    = queue_r[QIDX_W-1:0];
  assign ptr_cur_s = ptr_r[qidx_s];
  // The number of beats left before the next 4 KB boundary. Because the region
  // size is a multiple of 4 KB, this limit also prevents a region wrap
  // inside a burst.
  assign tail_s    = (AW'(13'd4096) - AW'(ptr_cur_s[11:0])) >> BSHIFT;
  assign len_s     = LEN_W'(min_u(min_u(rem_r, AW'(P_MAX_BURST_LEN)), tail_s));
  assign base_s    = AW'(queue_r) * AW'(P_QUEUE_SPACE);
  assign ptr_nx_s  = (ptr_cur_s + (AW'(len_r) << BSHIFT)) & AW'(P_QUEUE_SPACE - 32'd1);
  // Round the byte count up to whole beats. The extra bit absorbs a carry
  // when the byte count is close to the maximum value.
  assign byte_sum_s = {1'b0, i_rd_byte} + (AW + 1)'(BYTES - 1);
  assign beats_s    = AW'(byte_sum_s >> BSHIFT);

  assign in_rdata_s = (state_r == RDATA);
  assign r_hs_s     = in_rdata_s & m_axi.rvalid & i_rd_ready;

  assign o_rd_byte_ready   = ready_r;
  assign o_rd_queue_finish = (state_r == FINISH);
  assign o_req_err         = (state_r == CALC) & queue_bad_r;
  assign o_rresp_err       = rresp_err_r;

  assign m_axi.araddr  = araddr_r;
  assign m_axi.arlen   = arlen_r;
  assign m_axi.arsize  = 3'(BSHIFT);
  assign m_axi.arburst = 2'b01;
  assign m_axi.arvalid = (state_r == AR);
  assign m_axi.rready  = in_rdata_s & i_rd_ready;

  assign o_rd_valid = in_rdata_s & m_axi.rvalid;
  assign o_rd_data  = in_rdata_s ? m_axi.rdata : {DW{1'b0}};
  assign o_rd_flag  = in_rdata_s & flag_r;
  assign o_rd_last  = in_rdata_s & m_axi.rlast & (rem_r == {AW{1'b0}});

  // Next-state logic.
  always_comb begin
    state_nx_s = state_r;
    case (state_r)
      IDLE: begin
        if (i_rd_byte_valid && ready_r) begin
          state_nx_s = CALC;
        end else begin
          state_nx_s = IDLE;
        end
      end
      CALC: begin
        if (queue_bad_r || (rem_r == {AW{1'b0}})) begin
          state_nx_s = FINISH;
        end else begin
          state_nx_s = AR;
        end
      end
      AR: begin
        if (m_axi.arready) begin
          state_nx_s = RDATA;
        end else begin
          state_nx_s = AR;
        end
      end
      RDATA: begin
        if (r_hs_s && m_axi.rlast) begin
          state_nx_s = (rem_r == {AW{1'b0}}) ? FINISH : CALC;
        end else begin
          state_nx_s = RDATA;
        end
      end
      FINISH:  state_nx_s = IDLE;
      default: state_nx_s = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nx_s;
    end
  end

  // Command latch, burst setup, per-queue pointers and the sticky error flag.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      ready_r     <= 1'b0;
      queue_r     <= {QW{1'b0}};
      queue_bad_r <= 1'b0;
      flag_r      <= 1'b0;
      rem_r       <= {AW{1'b0}};
      len_r       <= {LEN_W{1'b0}};
      araddr_r    <= {AW{1'b0}};
      arlen_r     <= 8'd0;
      rresp_err_r <= 1'b0;
      for (int i = 0; i < P_QUEUE_NUM; i++) begin
        ptr_r[i] <= {AW{1'b0}};
      end
    end else begin
      // Registered ready. It stays low for one cycle after reset and
      // otherwise follows the IDLE state.
      ready_r <= (state_nx_s == IDLE);
      case (state_r)
        IDLE: begin
          if (i_rd_byte_valid && ready_r) begin
            queue_r     <= i_rd_queue;
            queue_bad_r <= ({1'b0, i_rd_queue} >= QNUM);
            flag_r      <= i_rd_flag;
            rem_r       <= beats_s;
          end
        end
        CALC: begin
          if (!queue_bad_r && (rem_r != {AW{1'b0}})) begin
            araddr_r <= base_s + ptr_cur_s;
            arlen_r  <= 8'(len_s - LEN_W'(1));
            len_r    <= len_s;
          end
        end
        AR: begin
          if (m_axi.arready) begin
            ptr_r[qidx_s] <= ptr_nx_s;
            rem_r         <= rem_r - AW'(len_r);
          end
        end
        RDATA: begin
          if (r_hs_s && (m_axi.rresp != 2'b00)) begin
            rresp_err_r <= 1'b1;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rd_ddr_burst_ctrl.sv
// Self-checking bench for rd_ddr_burst_ctrl.
// The bench builds two instances. The first uses the default 4 MB queue regions.
// The second uses 8 KB regions, so the circular pointer wrap can be exercised
// quickly. A single set of drivers is routed to the selected instance.
// A queue-based reference model computes the expected list of bursts and the
// expected per-queue pointers from the byte arithmetic.
module tb_rd_ddr_burst_ctrl;
  localparam int AW = 32;
  localparam int DW = 512;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n;
  logic          sel;
  logic          cmd_valid, cmd_flag;
  logic [3:0]    cmd_queue;
  logic [31:0]   cmd_byte;
  logic          arready_d, rlast_d, rvalid_d, rd_ready_d;
  logic [1:0]    rresp_d;
  logic [DW-1:0] rdata_d;

  int checks = 0;
  int failures = 0;

  int unsigned mptr [2][8];
  bit          exp_rresp [2];

  rd_ddr_burst_ctrl_if #(.AW(AW), .DW(DW)) ax0 ();
  rd_ddr_burst_ctrl_if #(.AW(AW), .DW(DW)) ax1 ();

  assign ax0.arready = arready_d & ~sel;
  assign ax0.rvalid  = rvalid_d & ~sel;
  assign ax0.rdata   = rdata_d;
  assign ax0.rresp   = rresp_d;
  assign ax0.rlast   = rlast_d;
  assign ax1.arready = arready_d & sel;
  assign ax1.rvalid  = rvalid_d & sel;
  assign ax1.rdata   = rdata_d;
  assign ax1.rresp   = rresp_d;
  assign ax1.rlast   = rlast_d;

  logic [1:0]    byte_ready_v, finish_v, req_err_v, rd_flag_v, rd_valid_v, rd_last_v, rresp_err_v;
  logic [DW-1:0] rd_data_v [2];

  rd_ddr_burst_ctrl #(.P_QUEUE_SPACE(32'h0040_0000)) dut0 (
    .i_clk(clk), .i_rst_n(rst_n), .i_rd_flag(cmd_flag), .i_rd_queue(cmd_queue),
    .i_rd_byte(cmd_byte), .i_rd_byte_valid(cmd_valid & ~sel),
    .o_rd_byte_ready(byte_ready_v[0]), .o_rd_queue_finish(finish_v[0]), .o_req_err(req_err_v[0]),
    .m_axi(ax0), .o_rd_data(rd_data_v[0]), .o_rd_flag(rd_flag_v[0]), .o_rd_valid(rd_valid_v[0]),
    .o_rd_last(rd_last_v[0]), .i_rd_ready(rd_ready_d & ~sel), .o_rresp_err(rresp_err_v[0])
  );

  rd_ddr_burst_ctrl #(.P_QUEUE_SPACE(32'h0000_2000)) dut1 (
    .i_clk(clk), .i_rst_n(rst_n), .i_rd_flag(cmd_flag), .i_rd_queue(cmd_queue),
    .i_rd_byte(cmd_byte), .i_rd_byte_valid(cmd_valid & sel),
    .o_rd_byte_ready(byte_ready_v[1]), .o_rd_queue_finish(finish_v[1]), .o_req_err(req_err_v[1]),
    .m_axi(ax1), .o_rd_data(rd_data_v[1]), .o_rd_flag(rd_flag_v[1]), .o_rd_valid(rd_valid_v[1]),
    .o_rd_last(rd_last_v[1]), .i_rd_ready(rd_ready_d & sel), .o_rresp_err(rresp_err_v[1])
  );

  logic          byte_ready_m, finish_m, req_err_m, rd_flag_m, rd_valid_m, rd_last_m, rresp_err_m;
  logic [DW-1:0] rd_data_m;
  logic [AW-1:0] araddr_m;
  logic [7:0]    arlen_m;
  logic [2:0]    arsize_m;
  logic [1:0]    arburst_m;
  logic          arvalid_m, rready_m;

  assign byte_ready_m = byte_ready_v[sel];
  assign finish_m     = finish_v[sel];
  assign req_err_m    = req_err_v[sel];
  assign rd_flag_m    = rd_flag_v[sel];
  assign rd_valid_m   = rd_valid_v[sel];
  assign rd_last_m    = rd_last_v[sel];
  assign rresp_err_m  = rresp_err_v[sel];
  assign rd_data_m    = sel ? rd_data_v[1] : rd_data_v[0];
  assign araddr_m     = sel ? ax1.araddr  : ax0.araddr;
  assign arlen_m      = sel ? ax1.arlen   : ax0.arlen;
  assign arsize_m     = sel ? ax1.arsize  : ax0.arsize;
  assign arburst_m    = sel ? ax1.arburst : ax0.arburst;
  assign arvalid_m    = sel ? ax1.arvalid : ax0.arvalid;
  assign rready_m     = sel ? ax1.rready  : ax0.rready;

  task automatic check_val(input string tag, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  function automatic int unsigned space_of(input bit s);
    return s ? 32'h0000_2000 : 32'h0040_0000;
  endfunction

  task automatic idle_inputs();
    cmd_valid = 1'b0; cmd_flag = 1'b0; cmd_queue = 4'd0; cmd_byte = 32'd0;
    arready_d = 1'b0; rvalid_d = 1'b0; rlast_d = 1'b0; rresp_d = 2'd0;
    rdata_d = '0; rd_ready_d = 1'b0;
  endtask

  task automatic reset_model();
    for (int s = 0; s < 2; s++) begin
      exp_rresp[s] = 1'b0;
      for (int q = 0; q < 8; q++) mptr[s][q] = 0;
    end
  endtask

  // Called while rst_n is low. It checks both instances.
  task automatic check_reset_outputs();
    logic keep;
    keep = sel;
    for (int s = 0; s < 2; s++) begin
      sel = s[0];
      #1;
      check_val("rst_byte_ready", byte_ready_m, 1'b0);
      check_val("rst_finish", finish_m, 1'b0);
      check_val("rst_req_err", req_err_m, 1'b0);
      check_val("rst_araddr", araddr_m, 32'd0);
      check_val("rst_arlen", arlen_m, 8'd0);
      check_val("rst_arsize", arsize_m, 3'd6);
      check_val("rst_arburst", arburst_m, 2'b01);
      check_val("rst_arvalid", arvalid_m, 1'b0);
      check_val("rst_rready", rready_m, 1'b0);
      check_val("rst_rd_data", rd_data_m, '0);
      check_val("rst_rd_flag", rd_flag_m, 1'b0);
      check_val("rst_rd_valid", rd_valid_m, 1'b0);
      check_val("rst_rd_last", rd_last_m, 1'b0);
      check_val("rst_rresp_err", rresp_err_m, 1'b0);
    end
    sel = keep;
    #1;
  endtask

  // This task issues one command and acts as the AXI slave and the
  // downstream sink. An abort_beat >= 0 applies reset right after that
  // many beats have been accepted.
  task automatic run_cmd(input bit s, input int q, input int unsigned nbytes, input bit flag,
                         input int stall_n, input int rdy_pct, input int err_beat, input int abort_beat);
    int unsigned ex_addr[$];
    int          ex_len[$];
    int unsigned ptr, rem, len, tail, total;
    bit          bad, accepted, have_beat, aborted, exp_last;
    int          t, budget, acc_t, first_ar_t, fin_t, last_beat_t, done_t;
    int          ar_cnt, ar_vis, fin_cnt, err_cnt, spurious, beats_left, beat_idx, n_ar;
    logic [DW-1:0] beat_data;

    bad   = (q >= 8);
    total = bad ? 0 : (nbytes + 63) / 64;
    if (!bad) begin
      ptr = mptr[s][q];
      rem = total;
      while (rem > 0) begin
        tail = (4096 - (ptr % 4096)) / 64;
        len  = rem;
        if (len > 64) len = 64;
        if (len > tail) len = tail;
        ex_addr.push_back(q * space_of(s) + ptr);
        ex_len.push_back(len);
        ptr = (ptr + len * 64) % space_of(s);
        rem -= len;
      end
      mptr[s][q] = ptr;
    end
    n_ar   = ex_addr.size();
    budget = 100 + int'(total) * 12 + n_ar * (stall_n + 12);

    accepted = 0; have_beat = 0; aborted = 0; beat_data = '0;
    acc_t = -1; first_ar_t = -1; fin_t = -1; last_beat_t = -1; done_t = -1;
    ar_cnt = 0; ar_vis = 0; fin_cnt = 0; err_cnt = 0; spurious = 0; beats_left = 0; beat_idx = 0;
    sel = s; cmd_queue = 4'(q); cmd_byte = nbytes; cmd_flag = flag;

    t = 0;
    while (t < budget && !(done_t >= 0 && t > done_t) && !aborted) begin
      @(negedge clk);
      cmd_valid  = !accepted;
      arready_d  = (ar_vis >= stall_n);
      rd_ready_d = ($urandom_range(99) >= rdy_pct);
      if (beats_left > 0) begin
        if (!have_beat) begin
          for (int k = 0; k < DW / 32; k++) beat_data[k*32 +: 32] = $urandom;
          have_beat = 1;
        end
        rvalid_d = ($urandom_range(3) != 0);
        rdata_d  = beat_data;
        rlast_d  = (beats_left == 1);
        rresp_d  = (beat_idx == err_beat) ? 2'd2 : 2'd0;
      end else begin
        rvalid_d = 1'b0; rlast_d = 1'b0; rresp_d = 2'd0; rdata_d = '0;
      end
      #1;
      if (finish_m) begin
        fin_cnt++;
        fin_t = t;
        if (done_t < 0) done_t = t + 2;
      end
      if (req_err_m) err_cnt++;
      if (!accepted && byte_ready_m) begin
        accepted = 1;
        acc_t = t;
      end
      if (arvalid_m && beats_left > 0) spurious++;
      if (beats_left > 0) begin
        check_val("rready_pass", rready_m, rd_ready_d);
        check_val("rvalid_pass", rd_valid_m, rvalid_d);
        if (rvalid_d && rd_ready_d) begin
          exp_last = (beats_left == 1) && (ex_addr.size() == 0);
          check_val("rd_data", rd_data_m, beat_data);
          check_val("rd_flag", rd_flag_m, flag);
          check_val("rd_last", rd_last_m, exp_last);
          if (rresp_d != 2'd0) exp_rresp[s] = 1'b1;
          beats_left--;
          beat_idx++;
          have_beat = 0;
          last_beat_t = t;
          if (beat_idx == abort_beat) aborted = 1;
        end
      end else if (arvalid_m) begin
        if (first_ar_t < 0) first_ar_t = t;
        if (ex_addr.size() > 0) begin
          check_val("araddr", araddr_m, ex_addr[0]);
          check_val("arlen", arlen_m, 8'(ex_len[0] - 1));
          check_val("arsize", arsize_m, 3'd6);
          check_val("arburst", arburst_m, 2'b01);
          ar_vis++;
          if (arready_d) begin
            ar_cnt++;
            beats_left = ex_len.pop_front();
            void'(ex_addr.pop_front());
            ar_vis = 0;
          end
        end else begin
          spurious++;
        end
      end
      t++;
    end

    if (aborted) begin
      @(negedge clk);
      rst_n = 1'b0;
      idle_inputs();
      reset_model();
      check_reset_outputs();
      @(negedge clk);
      rst_n = 1'b1;
    end else begin
      check_val("accepted", accepted, 1'b1);
      check_val("finish_count", fin_cnt, 1);
      check_val("req_err_count", err_cnt, bad);
      check_val("ar_count", ar_cnt, n_ar);
      check_val("ar_spurious", spurious, 0);
      check_val("beat_count", beat_idx, total);
      check_val("rresp_err", rresp_err_m, exp_rresp[s]);
      check_val("ready_after", byte_ready_m, 1'b1);
      if (n_ar > 0) begin
        check_val("ar_latency", first_ar_t - acc_t, 2);
        check_val("fin_after_beat", fin_t - last_beat_t, 1);
      end else begin
        check_val("fin_latency", fin_t - acc_t, 2);
      end
    end
  endtask

  initial begin
    rst_n = 1'b0;
    sel   = 1'b0;
    idle_inputs();
    reset_model();
    repeat (3) @(negedge clk);
    check_reset_outputs();
    @(negedge clk);
    rst_n = 1'b1;

    run_cmd(1'b0, 2, 100, 1'b1, 0, 0, -1, -1);     // one 2-beat burst at 0x0080_0000
    run_cmd(1'b0, 2, 4096, 1'b0, 0, 30, -1, -1);   // split at the 4 KB boundary
    run_cmd(1'b0, 3, 300, 1'b1, 5, 50, -1, -1);    // arready held low for 5 cycles
    run_cmd(1'b0, 0, 0, 1'b0, 0, 0, -1, -1);       // zero-byte command
    run_cmd(1'b0, 9, 64, 1'b1, 0, 0, -1, -1);      // queue index out of range
    run_cmd(1'b1, 1, 8128, 1'b0, 1, 20, -1, -1);   // pointer moves to 0x1FC0
    run_cmd(1'b1, 1, 128, 1'b1, 0, 0, -1, -1);     // wraps inside the region
    run_cmd(1'b0, 4, 256, 1'b0, 0, 0, 2, -1);      // rresp error on one beat

    for (int i = 0; i < 40; i++) begin
      run_cmd(1'($urandom_range(1)), int'($urandom_range(9)), $urandom_range(6000),
              1'($urandom_range(1)), int'($urandom_range(3)), int'($urandom_range(60)), -1, -1);
    end

    run_cmd(1'b0, 2, 512, 1'b1, 0, 0, -1, 3);      // reset in the middle of the data phase
    run_cmd(1'b0, 2, 64, 1'b0, 0, 0, -1, -1);      // pointer starts at 0 again

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
